// File: rtl/mem_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : mem_stall_controller
// Purpose  : Stalls the pipeline while instruction/data memory responses are
//            outstanding, holding early responses until both sides are ready.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stall_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_req,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        dmem_rd_req,
    input  logic        dmem_wr_req,
    input  logic        dmem_resp,
    input  logic [31:0] dmem_rdata,
    output logic        imem_read,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] instr_out,
    output logic [31:0] load_data_out,
    output logic        stall_pipeline,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_BOTH = 2'd1,
        WAIT_I    = 2'd2,
        WAIT_D    = 2'd3
    } state_t;

    localparam logic [31:0] c_count_max = 32'hFFFF_FFFF;

    state_t      state_q, state_d;
    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;
    logic [31:0] i_hold_q, i_hold_d;
    logic [31:0] d_hold_q, d_hold_d;
    logic [31:0] stall_count_q, stall_count_d;

    logic        w_d_req;
    logic        w_i_pend;
    logic        w_d_pend;

    // State only tracks what is outstanding for debug; no output depends on it.
    logic [1:0]  w_unused_state;
    assign w_unused_state = state_q;

    assign w_d_req   = dmem_rd_req | dmem_wr_req;
    assign w_i_pend  = imem_req & ~i_done_q & ~imem_resp;
    assign w_d_pend  = w_d_req & ~d_done_q & ~dmem_resp;

    assign stall_pipeline = w_i_pend | w_d_pend;
    assign imem_read      = imem_req & ~i_done_q;
    assign dmem_read      = dmem_rd_req & ~d_done_q;
    assign dmem_write     = dmem_wr_req & ~d_done_q & ~dmem_rd_req;
    assign instr_out      = i_done_q ? i_hold_q : imem_rdata;
    assign load_data_out  = d_done_q ? d_hold_q : dmem_rdata;
    assign stall_count    = stall_count_q;

    always_comb begin
        i_done_d      = i_done_q;
        d_done_d      = d_done_q;
        i_hold_d      = i_hold_q;
        d_hold_d      = d_hold_q;
        stall_count_d = stall_count_q;
        state_d       = RUN;

        if (stall_pipeline) begin
            // Capture each side once; later responses leave the hold intact.
            if (imem_resp && !i_done_q) begin
                i_done_d = 1'b1;
                i_hold_d = imem_rdata;
            end
            if (dmem_resp && !d_done_q) begin
                d_done_d = 1'b1;
                d_hold_d = dmem_rdata;
            end
            if (stall_count_q != c_count_max) begin
                stall_count_d = stall_count_q + 32'd1;
            end
        end else begin
            i_done_d = 1'b0;
            d_done_d = 1'b0;
        end

        case ({w_i_pend, w_d_pend})
            2'b11:   state_d = WAIT_BOTH;
            2'b10:   state_d = WAIT_I;
            2'b01:   state_d = WAIT_D;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            i_done_q      <= 1'b0;
            d_done_q      <= 1'b0;
            i_hold_q      <= 32'd0;
            d_hold_q      <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            i_done_q      <= i_done_d;
            d_done_q      <= d_done_d;
            i_hold_q      <= i_hold_d;
            d_hold_q      <= d_hold_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule
`default_nettype wire
